// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multicycle MIPS controller: opcodes, functs, ALU ops,
// controller states, datapath selects and the decoded-instruction bundle.
package multicycle_controller_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_JR   = 6'h08,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMRD  = 3'd3,
    MEMWR  = 3'd4,
    WBACK  = 3'd5,
    HALTED = 3'd6
  } mc_state_t;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RS     = 2'd3
  } pcsrc_t;

  typedef enum logic [1:0] {
    RD_RT = 2'd0,
    RD_RD = 2'd1,
    RD_RA = 2'd2
  } regdst_t;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC4 = 2'd2,
    WD_LUI = 2'd3
  } regwdsel_t;

  typedef struct packed {
    regdst_t   regdst;
    regwdsel_t regwdsel;
    pcsrc_t    pcsrc;
    logic      alusrc;
    logic      extop;
    aluop_t    aluop;
    logic      is_branch;
    logic      branch_ne;
    logic      is_load;
    logic      is_store;
    logic      is_jump;
    logic      is_jal;
    logic      is_jr;
    logic      is_halt;
    logic      is_illegal;
  } dec_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/request-unit bundle: instruction and hit inputs,
// strobes, selects and counters.
interface multicycle_controller_if
  import multicycle_controller_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  logic [WORD_W-1:0] instruction;
  logic              ihit;
  logic              dhit;
  logic              zero;
  logic              iREN;
  logic              dREN;
  logic              dWEN;
  logic              irWEN;
  logic              pcWEN;
  logic              RegWEN;
  regdst_t           RegDst;
  regwdsel_t         RegWDsel;
  pcsrc_t            PCSrc;
  logic              ALUSrc;
  logic              ExtOp;
  aluop_t            aluop;
  logic              halt;
  logic              illegal;
  logic [CNT_W-1:0]  retired;
  logic [CNT_W-1:0]  cycles;

  modport master (
    input  instruction, ihit, dhit, zero,
    output iREN, dREN, dWEN, irWEN, pcWEN, RegWEN, RegDst, RegWDsel, PCSrc,
           ALUSrc, ExtOp, aluop, halt, illegal, retired, cycles
  );

  modport slave (
    output instruction, ihit, dhit, zero,
    input  iREN, dREN, dWEN, irWEN, pcWEN, RegWEN, RegDst, RegWDsel, PCSrc,
           ALUSrc, ExtOp, aluop, halt, illegal, retired, cycles
  );
endinterface

// File: rtl/multicycle_controller_decode.sv
// Combinational instruction decode: datapath selects, ALU op and class flags.
// Unknown opcodes and unknown R-type functs both flag is_illegal.
module mc_decode
  import multicycle_controller_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] instruction_i,
  output dec_t              dec_o
);
  opcode_t op;
  funct_t  fn;
  logic    unused_fields;

  assign op            = opcode_t'(instruction_i[WORD_W-1 -: 6]);
  assign fn            = funct_t'(instruction_i[5:0]);
  assign unused_fields = ^instruction_i[WORD_W-7:6];

  always_comb begin
    dec_o = '0;
    unique case (op)
      OP_RTYPE: begin
        dec_o.regdst = RD_RD;
        case (fn)
          FN_SLL:          begin dec_o.alusrc = 1'b1; dec_o.aluop = ALU_SLL; end
          FN_SRL:          begin dec_o.alusrc = 1'b1; dec_o.aluop = ALU_SRL; end
          FN_JR:           begin dec_o.is_jr = 1'b1; dec_o.pcsrc = PC_RS; end
          FN_ADD, FN_ADDU: dec_o.aluop = ALU_ADD;
          FN_SUB, FN_SUBU: dec_o.aluop = ALU_SUB;
          FN_AND:          dec_o.aluop = ALU_AND;
          FN_OR:           dec_o.aluop = ALU_OR;
          FN_XOR:          dec_o.aluop = ALU_XOR;
          FN_NOR:          dec_o.aluop = ALU_NOR;
          FN_SLT:          dec_o.aluop = ALU_SLT;
          FN_SLTU:         dec_o.aluop = ALU_SLTU;
          default:         dec_o.is_illegal = 1'b1;
        endcase
      end
      OP_J:   begin dec_o.is_jump = 1'b1; dec_o.pcsrc = PC_JUMP; end
      OP_JAL: begin
        dec_o.is_jal   = 1'b1;
        dec_o.pcsrc    = PC_JUMP;
        dec_o.regdst   = RD_RA;
        dec_o.regwdsel = WD_PC4;
      end
      OP_BEQ, OP_BNE: begin
        dec_o.is_branch = 1'b1;
        dec_o.branch_ne = (op == OP_BNE);
        dec_o.extop     = 1'b1;
        dec_o.aluop     = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU: begin dec_o.alusrc = 1'b1; dec_o.extop = 1'b1; dec_o.aluop = ALU_ADD; end
      OP_SLTI:  begin dec_o.alusrc = 1'b1; dec_o.extop = 1'b1; dec_o.aluop = ALU_SLT; end
      OP_SLTIU: begin dec_o.alusrc = 1'b1; dec_o.extop = 1'b1; dec_o.aluop = ALU_SLTU; end
      OP_ANDI:  begin dec_o.alusrc = 1'b1; dec_o.aluop = ALU_AND; end
      OP_ORI:   begin dec_o.alusrc = 1'b1; dec_o.aluop = ALU_OR; end
      OP_XORI:  begin dec_o.alusrc = 1'b1; dec_o.aluop = ALU_XOR; end
      OP_LUI:   begin dec_o.alusrc = 1'b1; dec_o.regwdsel = WD_LUI; dec_o.aluop = ALU_ADD; end
      OP_LW: begin
        dec_o.is_load  = 1'b1;
        dec_o.alusrc   = 1'b1;
        dec_o.extop    = 1'b1;
        dec_o.aluop    = ALU_ADD;
        dec_o.regwdsel = WD_MEM;
      end
      OP_SW: begin
        dec_o.is_store = 1'b1;
        dec_o.alusrc   = 1'b1;
        dec_o.extop    = 1'b1;
        dec_o.aluop    = ALU_ADD;
      end
      OP_HALT: dec_o.is_halt = 1'b1;
      default: dec_o.is_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller: sequences FETCH..WBACK around ihit/dhit handshakes,
// drives datapath strobes/selects and keeps saturating retired/cycle counters.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input logic                    CLK,
  input logic                    RST,
  multicycle_controller_if.master bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mc_state_t        state_q, state_d;
  dec_t             dec;
  pcsrc_t           pcsrc;
  logic             sel_active;
  logic             iren, dren, dwen, irwen, pcwen, regwen, illegal;
  logic [CNT_W-1:0] retired_q, retired_d, cycles_q, cycles_d;

  mc_decode #(.WORD_W(WORD_W)) u_decode (
    .instruction_i (bus.instruction),
    .dec_o         (dec)
  );

  // Strobes are forced low while RST is held so reset takes effect mid-cycle.
  always_comb begin
    state_d = state_q;
    iren    = 1'b0;
    dren    = 1'b0;
    dwen    = 1'b0;
    irwen   = 1'b0;
    pcwen   = 1'b0;
    regwen  = 1'b0;
    illegal = 1'b0;
    if (!RST) begin
      case (state_q)
        FETCH: begin
          iren = 1'b1;
          if (bus.ihit) begin
            irwen   = 1'b1;
            state_d = DECODE;
          end
        end
        DECODE: begin
          if (dec.is_halt) begin
            state_d = HALTED;
          end else if (dec.is_jump) begin
            pcwen   = 1'b1;
            state_d = FETCH;
          end else if (dec.is_jal) begin
            state_d = WBACK;
          end else if (dec.is_illegal) begin
            illegal = 1'b1;
            pcwen   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          if (dec.is_branch || dec.is_jr) begin
            pcwen   = 1'b1;
            state_d = FETCH;
          end else if (dec.is_load) begin
            state_d = MEMRD;
          end else if (dec.is_store) begin
            state_d = MEMWR;
          end else begin
            state_d = WBACK;
          end
        end
        MEMRD: begin
          dren = 1'b1;
          if (bus.dhit) state_d = WBACK;
        end
        MEMWR: begin
          dwen = 1'b1;
          if (bus.dhit) begin
            pcwen   = 1'b1;
            state_d = FETCH;
          end
        end
        WBACK: begin
          regwen  = 1'b1;
          pcwen   = 1'b1;
          state_d = FETCH;
        end
        HALTED:  state_d = HALTED;
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    pcsrc = dec.pcsrc;
    if (dec.is_branch) pcsrc = (bus.zero ^ dec.branch_ne) ? PC_BRANCH : PC_NEXT;
  end

  assign retired_d = (pcwen && retired_q != CNT_MAX) ? retired_q + CNT_W'(1) : retired_q;
  assign cycles_d  = (state_q != HALTED && cycles_q != CNT_MAX) ? cycles_q + CNT_W'(1) : cycles_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= FETCH;
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      cycles_q  <= cycles_d;
    end
  end

  // Selects track the decoded instruction from DECODE through its last state.
  assign sel_active = !RST && (state_q != FETCH) && (state_q != HALTED);

  assign bus.RegDst   = sel_active ? dec.regdst   : RD_RT;
  assign bus.RegWDsel = sel_active ? dec.regwdsel : WD_ALU;
  assign bus.PCSrc    = sel_active ? pcsrc        : PC_NEXT;
  assign bus.ALUSrc   = sel_active & dec.alusrc;
  assign bus.ExtOp    = sel_active & dec.extop;
  assign bus.aluop    = sel_active ? dec.aluop    : aluop_t'(4'd0);

  assign bus.iREN    = iren;
  assign bus.dREN    = dren;
  assign bus.dWEN    = dwen;
  assign bus.irWEN   = irwen;
  assign bus.pcWEN   = pcwen;
  assign bus.RegWEN  = regwen;
  assign bus.illegal = illegal;
  assign bus.halt    = !RST && (state_q == HALTED);
  assign bus.retired = retired_q;
  assign bus.cycles  = cycles_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; a CNT_W=4 twin shares the stimulus
// so counter saturation can be observed.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        ihit = 1'b0;
  logic        dhit = 1'b0;
  logic        zero = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  localparam logic [31:0] I_ADD  = 32'h00432020;
  localparam logic [31:0] I_LW   = 32'h8C220010;
  localparam logic [31:0] I_BEQ  = 32'h10220004;
  localparam logic [31:0] I_JAL  = 32'h0C0003E0;
  localparam logic [31:0] I_J    = 32'h08000100;
  localparam logic [31:0] I_BAD  = 32'hF8000000;
  localparam logic [31:0] I_HALT = 32'hFC000000;
  localparam logic [31:0] I_NOP  = 32'h00000000;

  always #5 CLK = ~CLK;

  multicycle_controller_if #(.WORD_W(32), .CNT_W(16)) b16 ();
  multicycle_controller_if #(.WORD_W(32), .CNT_W(4))  b4 ();

  assign b16.instruction = instr;
  assign b16.ihit        = ihit;
  assign b16.dhit        = dhit;
  assign b16.zero        = zero;
  assign b4.instruction  = instr;
  assign b4.ihit         = ihit;
  assign b4.dhit         = dhit;
  assign b4.zero         = zero;

  multicycle_controller #(.WORD_W(32), .CNT_W(16)) dut (.CLK(CLK), .RST(RST), .bus(b16.master));
  multicycle_controller #(.WORD_W(32), .CNT_W(4))  dut4 (.CLK(CLK), .RST(RST), .bus(b4.master));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_iren", b16.iREN, 1'b0);
    chk("rst_retired", b16.retired, 0);
    chk("rst_cycles", b16.cycles, 0);
    chk("rst_halt", b16.halt, 1'b0);

    // ADD with ihit three cycles late
    instr = I_ADD; RST = 1'b0; #1;
    chk("add_iren_f1", b16.iREN, 1'b1);
    chk("add_irwen_f1", b16.irWEN, 1'b0);
    nxt(); chk("add_iren_f2", b16.iREN, 1'b1);
    nxt(); chk("add_iren_f3", b16.iREN, 1'b1);
    chk("add_irwen_f3", b16.irWEN, 1'b0);
    nxt(); ihit = 1'b1; #1;
    chk("add_iren_f4", b16.iREN, 1'b1);
    chk("add_irwen_f4", b16.irWEN, 1'b1);
    nxt(); ihit = 1'b0; #1;
    chk("add_iren_dec", b16.iREN, 1'b0);
    chk("add_irwen_dec", b16.irWEN, 1'b0);
    chk("add_regdst_dec", b16.RegDst, 2'd1);
    nxt(); chk("add_regwen_exec", b16.RegWEN, 1'b0);
    nxt();
    chk("add_regwen_wb", b16.RegWEN, 1'b1);
    chk("add_regdst_wb", b16.RegDst, 2'd1);
    chk("add_pcwen_wb", b16.pcWEN, 1'b1);
    chk("add_pcsrc_wb", b16.PCSrc, 2'd0);
    nxt();
    chk("add_retired", b16.retired, 1);
    chk("add_cycles", b16.cycles, 7);
    chk("add_iren_next", b16.iREN, 1'b1);

    // LW with dhit two cycles late, ihit asserted during MEMRD
    instr = I_LW; ihit = 1'b1; #1;
    chk("lw_irwen", b16.irWEN, 1'b1);
    nxt(); ihit = 1'b0; #1;
    chk("lw_extop_dec", b16.ExtOp, 1'b1);
    nxt();
    chk("lw_extop_exec", b16.ExtOp, 1'b1);
    chk("lw_dren_exec", b16.dREN, 1'b0);
    nxt(); ihit = 1'b1; #1;
    chk("lw_dren_m1", b16.dREN, 1'b1);
    chk("lw_extop_m1", b16.ExtOp, 1'b1);
    chk("lw_iren_m1", b16.iREN, 1'b0);
    nxt(); ihit = 1'b0; #1;
    chk("lw_dren_m2", b16.dREN, 1'b1);
    nxt(); dhit = 1'b1; #1;
    chk("lw_dren_m3", b16.dREN, 1'b1);
    nxt(); dhit = 1'b0; #1;
    chk("lw_dren_wb", b16.dREN, 1'b0);
    chk("lw_regwen_wb", b16.RegWEN, 1'b1);
    chk("lw_wdsel_wb", b16.RegWDsel, 2'd1);
    chk("lw_extop_wb", b16.ExtOp, 1'b1);
    nxt(); chk("lw_retired", b16.retired, 2);

    // BEQ taken, then not taken
    instr = I_BEQ; ihit = 1'b1; #1;
    nxt(); ihit = 1'b0; #1;
    chk("beq1_pcwen_dec", b16.pcWEN, 1'b0);
    nxt(); zero = 1'b1; #1;
    chk("beq1_pcwen_exec", b16.pcWEN, 1'b1);
    chk("beq1_pcsrc_exec", b16.PCSrc, 2'd1);
    chk("beq1_regwen_exec", b16.RegWEN, 1'b0);
    nxt(); zero = 1'b0; #1;
    chk("beq1_pcwen_after", b16.pcWEN, 1'b0);
    chk("beq1_retired", b16.retired, 3);
    ihit = 1'b1; #1;
    nxt(); ihit = 1'b0; #1;
    chk("beq0_regwen_dec", b16.RegWEN, 1'b0);
    nxt();
    chk("beq0_pcwen_exec", b16.pcWEN, 1'b1);
    chk("beq0_pcsrc_exec", b16.PCSrc, 2'd0);
    chk("beq0_regwen_exec", b16.RegWEN, 1'b0);
    nxt(); chk("beq0_retired", b16.retired, 4);

    // JAL
    instr = I_JAL; ihit = 1'b1; #1;
    nxt(); ihit = 1'b0; #1;
    chk("jal_pcwen_dec", b16.pcWEN, 1'b0);
    nxt();
    chk("jal_regdst_wb", b16.RegDst, 2'd2);
    chk("jal_wdsel_wb", b16.RegWDsel, 2'd2);
    chk("jal_pcsrc_wb", b16.PCSrc, 2'd2);
    chk("jal_pcwen_wb", b16.pcWEN, 1'b1);
    chk("jal_regwen_wb", b16.RegWEN, 1'b1);
    nxt(); chk("jal_retired", b16.retired, 5);

    // J resolves in DECODE
    instr = I_J; ihit = 1'b1; #1;
    nxt(); ihit = 1'b0; #1;
    chk("j_pcwen_dec", b16.pcWEN, 1'b1);
    chk("j_pcsrc_dec", b16.PCSrc, 2'd2);
    nxt(); chk("j_iren_next", b16.iREN, 1'b1);

    // Unknown opcode becomes a NOP with an illegal pulse
    instr = I_BAD; ihit = 1'b1; #1;
    nxt(); ihit = 1'b0; #1;
    chk("bad_illegal_dec", b16.illegal, 1'b1);
    chk("bad_pcwen_dec", b16.pcWEN, 1'b1);
    chk("bad_pcsrc_dec", b16.PCSrc, 2'd0);
    nxt();
    chk("bad_illegal_after", b16.illegal, 1'b0);
    chk("bad_retired", b16.retired, 7);

    // dhit in FETCH has no effect
    dhit = 1'b1; #1;
    chk("fetch_dhit_irwen", b16.irWEN, 1'b0);
    nxt(); dhit = 1'b0; #1;
    chk("fetch_dhit_iren", b16.iREN, 1'b1);

    // Reset pulse in the middle of MEMRD
    instr = I_LW; ihit = 1'b1; #1;
    nxt(); ihit = 1'b0; #1;
    nxt(); nxt();
    chk("rstmid_dren_before", b16.dREN, 1'b1);
    RST = 1'b1; #1;
    chk("rstmid_dren", b16.dREN, 1'b0);
    chk("rstmid_retired", b16.retired, 0);
    chk("rstmid_cycles", b16.cycles, 0);
    nxt(); RST = 1'b0; #1;
    chk("rstmid_iren_first", b16.iREN, 1'b1);
    chk("rstmid_cycles_first", b16.cycles, 0);

    // 20 back-to-back NOPs, four cycles each
    instr = I_NOP; ihit = 1'b1; #1;
    repeat (80) nxt();
    chk("nop_retired16", b16.retired, 20);
    chk("nop_cycles16", b16.cycles, 80);
    chk("nop_retired4_sat", b4.retired, 15);
    chk("nop_cycles4_sat", b4.cycles, 15);

    // HALT, then hit noise
    instr = I_HALT; #1;
    nxt(); ihit = 1'b0; #1;
    chk("halt_dec", b16.halt, 1'b0);
    nxt();
    chk("halt_set", b16.halt, 1'b1);
    chk("halt_cycles", b16.cycles, 82);
    for (int i = 0; i < 6; i++) begin
      ihit = i[0];
      dhit = ~i[0];
      nxt();
      chk("halted_halt", b16.halt, 1'b1);
      chk("halted_iren", b16.iREN, 1'b0);
      chk("halted_dren", b16.dREN, 1'b0);
      chk("halted_pcwen", b16.pcWEN, 1'b0);
    end
    chk("halted_cycles_frozen", b16.cycles, 82);
    chk("halted_retired", b16.retired, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
